data_mem_port: RTL and testbench
================================

DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_read  input  1  read request strobe from the control path.
REQ-006 mem_write  input  1  write request strobe from the control path.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 write_data  input  32  store data (rt value).
REQ-009 read_data  output  32  load data; valid when done=1 for a read.
REQ-010 busy  output  1  high while a request is in flight; the pipeline stalls on it.
REQ-011 done  output  1  one-cycle pulse marking completion of the accepted request.
REQ-012 addr_err  output  1  one-cycle pulse with done when the request was rejected.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: accepts requests.
- WAIT: counts latency.
- RESP: asserts done for one cycle, then returns to IDLE.
REQ-014 In IDLE, exactly one of mem_read/mem_write high SHALL latch addr, write_data and the request type, load the counter with LATENCY-1, assert busy next cycle, and enter WAIT.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at zero the access SHALL occur and the state SHALL move to RESP.
- Read: read_data captures the word at addr[log2(DEPTH_WORDS)+1:2].
- Write: the word is updated.
REQ-016 Total latency SHALL be LATENCY+1 cycles from the request edge to the done pulse.
REQ-017 In RESP, done=1 and busy=0; read_data SHALL hold its value until the next read completes.
REQ-018 Requests presented while busy=1 or in RESP SHALL be ignored; the requester holds strobes until done.
REQ-019 Simultaneous mem_read=1 and mem_write=1 in IDLE SHALL be rejected: no storage access, straight to RESP with addr_err=1.
REQ-020 Address bits above the index range SHALL be ignored, so the address wraps modulo DEPTH_WORDS*4.
REQ-021 A read of a word never written SHALL return 0.

Reset
REQ-022 While reset=1, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-023 While reset=1, busy=0, done=0, addr_err=0 and read_data=0.
REQ-024 Reset mid-operation SHALL abort the request; an aborted write SHALL NOT modify storage.
REQ-025 Reset SHALL clear all storage words to 0 within DEPTH_WORDS cycles after deassertion.
- busy SHALL remain 1 during the clear.
- Requests during the clear SHALL be ignored.

Configuration
REQ-026 Macro DMEM_ALIGN_CHECK_EN defined: a request with addr[1:0] != 0 SHALL be rejected like REQ-019 (no access, addr_err=1 with done).
REQ-027 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored and addr_err SHALL be asserted only under REQ-019.

Structure
REQ-028 A shared package SHALL hold:
- the FSM state encoding (IDLE, WAIT, RESP, CLEAR);
- the word width constant 32;
- the request-type encoding.
REQ-029 Storage SHALL be a sub-module dmem_array: single port, synchronous write, registered read, plus a clear-index write port for reset.

Verification
REQ-030 Reset, then write 0xDEADBEEF at addr 0x10 with LATENCY=2 -> busy high for cycles 1-2, done pulses in cycle 3, addr_err=0.
REQ-031 Read addr 0x10 after REQ-030 -> read_data=0xDEADBEEF with done after 3 cycles; read of addr 0x14 -> 0.
REQ-032 mem_read=mem_write=1 at addr 0x20 -> done and addr_err pulse one cycle later, and a following read of 0x20 returns its prior value.
REQ-033 Write 0x1 at addr 0x0, then with DEPTH_WORDS=256 read addr 0x400 -> 0x1 (wrap-around).
REQ-034 Reset asserted mid-WAIT of a write of 0x55 to 0x8, then read 0x8 after the clear completes -> 0, and no done is emitted for the aborted request.
REQ-035 With DMEM_ALIGN_CHECK_EN, a write to 0x3 -> addr_err=1 and storage unchanged; without it, a write to 0x3 updates word 0.

Source files
------------

// File: rtl/data_mem_port_pkg.sv
// Shared types for the data memory port: FSM states, request kinds, word width.
package data_mem_port_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      CLEAR
   } state_e;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_READ,
      REQ_WRITE,
      REQ_BAD
   } req_kind_e;

   // Conflicting strobes or a misaligned address both turn into a rejected request.
   function automatic req_kind_e classify(input logic rd, input logic wr, input logic misaligned);
      req_kind_e k;
      if (!rd && !wr)
         k = REQ_NONE;
      else if ((rd && wr) || misaligned)
         k = REQ_BAD;
      else if (wr)
         k = REQ_WRITE;
      else
         k = REQ_READ;
      return k;
   endfunction

endpackage

// File: rtl/data_mem_port_array.sv
// dmem_array: single-port word storage, synchronous write, registered read,
// plus a dedicated clear port used to zero the array after reset.
module dmem_array
   import data_mem_port_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              acc_en,
   input  logic              acc_we,
   input  logic [IDX_W-1:0]  acc_idx,
   input  logic [WORD_W-1:0] acc_wdata,
   input  logic              clr_en,
   input  logic [IDX_W-1:0]  clr_idx,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_idx] <= '0;
      else if (acc_en && acc_we)
         mem[acc_idx] <= acc_wdata;
   end

   // Read register only moves on a completed read, so it holds across writes.
   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else if (acc_en && !acc_we)
         rdata <= mem[acc_idx];
   end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: multi-cycle load/store port with fixed latency and post-reset clear.
// Optional macro DMEM_ALIGN_CHECK_EN rejects word-misaligned addresses.
module data_mem_port
   import data_mem_port_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              busy,
   output logic              done,
   output logic              addr_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef struct packed {
      req_kind_e         kind;
      logic [IDX_W-1:0]  idx;
      logic [WORD_W-1:0] wdata;
   } req_t;

   state_e           state, state_d;
   logic [3:0]       cnt, cnt_d;
   req_t             req_q, req_d;
   logic             clr_pend, clr_pend_d;
   logic [IDX_W-1:0] clr_idx, clr_idx_d;
   logic             clr_go, acc_go;
   logic             misaligned;
   req_kind_e        new_kind;
   logic             unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = |addr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // Bits above the index range are dropped so addresses wrap.
   assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

   assign new_kind = classify(mem_read, mem_write, misaligned);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         req_q    <= '0;
         clr_pend <= 1'b1;
         clr_idx  <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         req_q    <= req_d;
         clr_pend <= clr_pend_d;
         clr_idx  <= clr_idx_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      req_d      = req_q;
      clr_pend_d = clr_pend;
      clr_idx_d  = clr_idx;
      clr_go     = 1'b0;
      acc_go     = 1'b0;
      case (state)
         IDLE: begin
            // The first post-reset cycle already writes word 0 of the clear.
            if (clr_pend) begin
               clr_go    = 1'b1;
               clr_idx_d = clr_idx + 1'b1;
               state_d   = CLEAR;
            end else if (new_kind != REQ_NONE) begin
               req_d.kind  = new_kind;
               req_d.idx   = addr[IDX_W+1:2];
               req_d.wdata = write_data;
               if (new_kind == REQ_BAD) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = 4'(LATENCY - 1);
                  state_d = WAIT;
               end
            end
         end
         CLEAR: begin
            clr_go = 1'b1;
            if (&clr_idx) begin
               clr_pend_d = 1'b0;
               clr_idx_d  = '0;
               state_d    = IDLE;
            end else begin
               clr_idx_d = clr_idx + 1'b1;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               acc_go  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy     = !reset && (clr_pend || state == WAIT);
   assign done     = (state == RESP);
   assign addr_err = (state == RESP) && (req_q.kind == REQ_BAD);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .acc_en    (acc_go && !reset),
      .acc_we    (req_q.kind == REQ_WRITE),
      .acc_idx   (req_q.idx),
      .acc_wdata (req_q.wdata),
      .clr_en    (clr_go && !reset),
      .clr_idx   (clr_idx),
      .rdata     (read_data)
   );

endmodule

// File: tb/tb_data_mem_port.sv
// Directed table-driven bench for data_mem_port (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_port;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [31:0] addr, write_data, read_data;
   logic        busy, done, addr_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   data_mem_port #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .busy       (busy),
      .done       (done),
      .addr_err   (addr_err)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic [7:0]  exp_busy;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a request at a negedge and hold it until done (bounded).
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [7:0] bmask, output logic err,
                         output logic [31:0] rdv, output logic done_after);
      mem_read   = rd;
      mem_write  = wr;
      addr       = a;
      write_data = wd;
      lat   = 0;
      bmask = '0;
      err   = 1'b0;
      rdv   = '0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat <= 8) bmask[lat-1] = busy;
         if (done) break;
      end
      err = addr_err;
      rdv = read_data;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic wait_clear(input logic poke, output int n, output int dones);
      n = 0;
      dones = 0;
      while (n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) dones++;
         if (poke && n == 5) begin
            mem_write  = 1'b1;
            addr       = 32'h30;
            write_data = 32'h99;
         end
         if (poke && n == 8) mem_write = 1'b0;
         if (!busy) break;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          lat, n, dn;
      logic [7:0]  bm;
      logic        er, dafter;
      logic [31:0] rv;

      vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 3, 8'h03};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 3, 8'h03};
      vecs[2]  = '{1'b1, 1'b0, 32'h30,       32'h0,        32'h0,        1'b0, 3, 8'h03};
      vecs[3]  = '{1'b1, 1'b0, 32'h14,       32'h0,        32'h0,        1'b0, 3, 8'h03};
      vecs[4]  = '{1'b0, 1'b1, 32'h20,       32'h12345678, 32'h0,        1'b0, 3, 8'h03};
      vecs[5]  = '{1'b1, 1'b1, 32'h20,       32'hFFFFFFFF, 32'h0,        1'b1, 1, 8'h00};
      vecs[6]  = '{1'b1, 1'b0, 32'h20,       32'h0,        32'h12345678, 1'b0, 3, 8'h03};
      vecs[7]  = '{1'b0, 1'b1, 32'h0,        32'h1,        32'h12345678, 1'b0, 3, 8'h03};
      vecs[8]  = '{1'b1, 1'b0, 32'h400,      32'h0,        32'h1,        1'b0, 3, 8'h03};
      vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFC10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 8'h03};
`ifdef DMEM_ALIGN_CHECK_EN
      vecs[10] = '{1'b0, 1'b1, 32'h3,        32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 1, 8'h00};
      vecs[12] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h1,        1'b0, 3, 8'h03};
`else
      vecs[10] = '{1'b0, 1'b1, 32'h3,        32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 3, 8'h03};
      vecs[12] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, 1'b0, 3, 8'h03};
`endif
      vecs[11] = '{1'b1, 1'b0, 32'h3FC,      32'h0,        32'h0,        1'b0, 3, 8'h03};

      reset      = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = '0;
      write_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",  {31'b0, busy},     32'h0);
      check("rst_done",  {31'b0, done},     32'h0);
      check("rst_err",   {31'b0, addr_err}, 32'h0);
      check("rst_rdata", read_data,         32'h0);

      reset = 1'b0;
      #1;
      check("clr_busy_start", {31'b0, busy}, 32'h1);
      wait_clear(1'b1, n, dn);
      check("clr_cycles", n,  DEPTH);
      check("clr_dones",  dn, 0);

      for (int i = 0; i < 13; i++) begin
         do_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, lat, bm, er, rv, dafter);
         check($sformatf("v%0d_lat", i),   lat,            vecs[i].exp_lat);
         check($sformatf("v%0d_err", i),   {31'b0, er},    {31'b0, vecs[i].exp_err});
         check($sformatf("v%0d_rdata", i), rv,             vecs[i].exp_rd);
         check($sformatf("v%0d_busy", i),  {24'b0, bm},    {24'b0, vecs[i].exp_busy});
         check($sformatf("v%0d_pulse", i), {31'b0, dafter}, 32'h0);
      end

      // Abort a write to 0x8 mid-WAIT with reset.
      mem_write  = 1'b1;
      addr       = 32'h8;
      write_data = 32'h55;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy_wait", {31'b0, busy}, 32'h1);
      reset     = 1'b1;
      mem_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_rst_busy",  {31'b0, busy},     32'h0);
      check("abort_rst_done",  {31'b0, done},     32'h0);
      check("abort_rst_err",   {31'b0, addr_err}, 32'h0);
      check("abort_rst_rdata", read_data,         32'h0);
      @(posedge clk);
      @(negedge clk);
      check("abort_rst_done2", {31'b0, done}, 32'h0);
      reset = 1'b0;
      #1;
      check("abort_clr_busy", {31'b0, busy}, 32'h1);
      wait_clear(1'b0, n, dn);
      check("abort_clr_cycles", n,  DEPTH);
      check("abort_clr_dones",  dn, 0);

      do_req(1'b1, 1'b0, 32'h8, 32'h0, lat, bm, er, rv, dafter);
      check("abort_rd8_lat",   lat, 3);
      check("abort_rd8_rdata", rv,  32'h0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, lat, bm, er, rv, dafter);
      check("cleared_rd10", rv, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
